// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine driver and its helpers.
//   gcd_drv_state_t     : driver FSM state encoding
//   GCD_NBITS_DEFAULT   : default operand/result width
//   GCD_TIMEOUT_DEFAULT : default watchdog limit in WAIT cycles
package gcd_pkg;

   localparam int unsigned GCD_NBITS_DEFAULT   = 32;
   localparam int unsigned GCD_TIMEOUT_DEFAULT = 1024;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      RESP_TO,
      DRAIN
   } gcd_drv_state_t;

endpackage

// File: rtl/gcd_driver_if.sv
// Request/response bus between a requester and the GCD driver.
//   req_valid/req_ready/req_a/req_b         : operand request handshake
//   rsp_valid/rsp_ready/rsp_result/rsp_timeout : result response handshake
//   modport master : requester side
//   modport slave  : driver side
interface gcd_driver_if
   import gcd_pkg::*;
#(
   parameter int unsigned nbits = GCD_NBITS_DEFAULT
);

   logic             req_valid;
   logic             req_ready;
   logic [nbits-1:0] req_a;
   logic [nbits-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [nbits-1:0] rsp_result;
   logic             rsp_timeout;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_timeout
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_timeout
   );

endinterface

// File: rtl/gcd_watchdog.sv
// Saturating cycle counter used as a watchdog.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : force the count back to zero (has priority over enable)
//   enable     : advance the count by one, holding at LIMIT-1
//   expired    : count has reached LIMIT-1
module gcd_watchdog #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned     CntW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(LIMIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CntMax);

endmodule

// File: rtl/gcd_driver.sv
// Front-end initiator for the subtract-and-swap GCD engine.
// Accepts one operand pair at a time, pulses the engine start, waits for its done pulse
// (or a watchdog timeout) and returns the result on the response handshake.
// After a timeout the engine is still running and cannot be aborted, so the driver drains
// its late done pulse before taking a new request.
// Optional: define GCD_DRIVER_ZERO_BYPASS_EN to answer requests with a zero operand
// directly (result a|b) without involving the engine.
//   clk, reset   : clock and asynchronous active-high reset
//   bus          : request/response handshake (slave side)
//   gcd_a, gcd_b : operands to the engine, held stable while it runs
//   gcd_start    : one-cycle engine start pulse
//   gcd_result   : engine result, sampled on gcd_done
//   gcd_done     : one-cycle engine completion pulse
module gcd_driver
   import gcd_pkg::*;
#(
   parameter int unsigned nbits          = GCD_NBITS_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   gcd_driver_if.slave      bus,
   output logic [nbits-1:0] gcd_a,
   output logic [nbits-1:0] gcd_b,
   output logic             gcd_start,
   input  logic [nbits-1:0] gcd_result,
   input  logic             gcd_done
);

   gcd_drv_state_t   state_q, state_d;
   logic [nbits-1:0] a_q, a_d;
   logic [nbits-1:0] b_q, b_d;
   logic [nbits-1:0] res_q, res_d;
   logic             to_q, to_d;
   logic             wd_clear, wd_enable, wd_expired;
   logic             bypass;

`ifdef GCD_DRIVER_ZERO_BYPASS_EN
   assign bypass = (bus.req_a == '0) || (bus.req_b == '0);
`else
   assign bypass = 1'b0;
`endif

   gcd_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      to_d      = to_q;
      wd_clear  = 1'b0;
      wd_enable = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               a_d = bus.req_a;
               b_d = bus.req_b;
               if (bypass) begin
                  res_d   = bus.req_a | bus.req_b;
                  to_d    = 1'b0;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            wd_clear = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            wd_enable = 1'b1;
            // done wins over a simultaneous expiry
            if (gcd_done) begin
               res_d   = gcd_result;
               to_d    = 1'b0;
               state_d = RESP;
            end else if (wd_expired) begin
               res_d   = '0;
               to_d    = 1'b1;
               state_d = RESP_TO;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         RESP_TO: begin
            if (bus.rsp_ready) state_d = DRAIN;
         end
         DRAIN: begin
            // the late done belongs to the timed-out request and is discarded
            if (gcd_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         to_q    <= to_d;
      end
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.rsp_valid   = (state_q == RESP) || (state_q == RESP_TO);
   assign bus.rsp_result  = res_q;
   assign bus.rsp_timeout = to_q;
   assign gcd_start       = (state_q == ISSUE);
   assign gcd_a           = a_q;
   assign gcd_b           = b_q;

`ifndef SYNTHESIS
   done_only_when_expected: assert property (@(posedge clk) disable iff (reset)
      gcd_done |-> ((state_q == WAIT) || (state_q == DRAIN)));
`endif

endmodule

// File: tb/tb_gcd_driver.sv
// Self-checking bench for gcd_driver with a behavioural engine whose latency is adjustable.
module tb_gcd_driver;

   localparam int unsigned NB = 32;
   localparam int unsigned TO = 8;

   typedef struct packed {
      logic [NB-1:0] res;
      logic          to;
   } exp_t;

   logic          clk;
   logic          reset;
   logic [NB-1:0] gcd_a, gcd_b, gcd_result;
   logic          gcd_start, gcd_done;

   exp_t exp_q[$];
   int   n_pass    = 0;
   int   n_total   = 0;
   int   cyc       = 0;
   int   done_cyc  = 0;
   int   hs_cyc    = -1000;
   int   min_gap   = 1000;
   int   start_cnt = 0;
   int   eng_lat   = 2;

   gcd_driver_if #(.nbits(NB)) bus ();

   gcd_driver #(
      .nbits          (NB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .gcd_a      (gcd_a),
      .gcd_b      (gcd_b),
      .gcd_start  (gcd_start),
      .gcd_result (gcd_result),
      .gcd_done   (gcd_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Euclid by remainder: the reference result
   function automatic logic [NB-1:0] ref_gcd(input logic [NB-1:0] a, input logic [NB-1:0] b);
      logic [NB-1:0] x, y, t;
      x = a;
      y = b;
      while (y != '0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // subtract-and-swap, as the real engine computes it
   function automatic logic [NB-1:0] sub_gcd(input logic [NB-1:0] a, input logic [NB-1:0] b);
      logic [NB-1:0] x, y, t;
      x = a;
      y = b;
      while (y != '0) begin
         if (x < y) begin
            t = x;
            x = y;
            y = t;
         end
         x = x - y;
      end
      return x;
   endfunction

   // Engine model: shares reset, cannot be aborted, done after eng_lat+1 busy cycles
   logic          eng_busy;
   int            eng_cnt;
   logic [NB-1:0] eng_res;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         eng_busy   <= 1'b0;
         eng_cnt    <= 0;
         eng_res    <= '0;
         gcd_done   <= 1'b0;
         gcd_result <= '0;
      end else begin
         gcd_done <= 1'b0;
         if (gcd_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_lat;
            eng_res  <= sub_gcd(gcd_a, gcd_b);
         end else if (eng_busy) begin
            if (eng_cnt == 0) begin
               gcd_done   <= 1'b1;
               gcd_result <= eng_res;
               eng_busy   <= 1'b0;
            end else begin
               eng_cnt <= eng_cnt - 1;
            end
         end
      end
   end

   // Cycle bookkeeping: done time, start count, handshake-to-start gap
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (gcd_done) done_cyc <= cyc;
      if (gcd_start) begin
         start_cnt <= start_cnt + 1;
         if ((cyc - hs_cyc) < min_gap) min_gap <= cyc - hs_cyc;
      end
      if (bus.rsp_valid && bus.rsp_ready) hs_cyc <= cyc;
   end

   task automatic check_word(input string tag, input logic [NB-1:0] obs,
                             input logic [NB-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_bit({pfx, "_req_ready"}, bus.req_ready, 1'b1);
      check_bit({pfx, "_rsp_valid"}, bus.rsp_valid, 1'b0);
      check_bit({pfx, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
      check_word({pfx, "_rsp_result"}, bus.rsp_result, '0);
      check_bit({pfx, "_gcd_start"}, gcd_start, 1'b0);
      check_word({pfx, "_gcd_a"}, gcd_a, '0);
      check_word({pfx, "_gcd_b"}, gcd_b, '0);
   endtask

   // Drive one request, push its expectation; returns 1ns after the accepting edge
   task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic to);
      exp_t e;
      int   w;
      e.res = to ? '0 : ref_gcd(a, b);
      e.to  = to;
      exp_q.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_a     = a;
      bus.req_b     = b;
      w = 0;
      @(negedge clk);
      while (!bus.req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) check_bit("req_ready_wait", bus.req_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int w;
      w = 0;
      while (!bus.rsp_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
   endtask

   // Waits for a response, pops and compares it, then completes the handshake
   task automatic get_rsp(input string tag);
      exp_t e;
      bus.rsp_ready = 1'b1;
      wait_valid();
      check_bit({tag, "_valid"}, bus.rsp_valid, 1'b1);
      check_word({tag, "_sb_depth"}, NB'(exp_q.size()), NB'(1));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_word({tag, "_result"}, bus.rsp_result, e.res);
         check_bit({tag, "_timeout"}, bus.rsp_timeout, e.to);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int            s0, c0, w;
      logic          ready_in_drain;
      logic [NB-1:0] ra, rb;

      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("rst");

      // 12,18: single start pulse, response the cycle after done
      s0 = start_cnt;
      send(32'd12, 32'd18, 1'b0);
      check_bit("t1_start_pulse", gcd_start, 1'b1);
      @(posedge clk);
      #1;
      check_bit("t1_start_one_cycle", gcd_start, 1'b0);
      wait_valid();
      check_word("t1_done_to_valid", NB'(cyc), NB'(done_cyc + 1));
      get_rsp("t1");
      repeat (4) @(posedge clk);
      #1;
      check_word("t1_start_count", NB'(start_cnt - s0), NB'(1));

      // zero operands
      s0 = start_cnt;
      send(32'd0, 32'd0, 1'b0);
`ifdef GCD_DRIVER_ZERO_BYPASS_EN
      check_bit("byp00_valid_next", bus.rsp_valid, 1'b1);
`endif
      get_rsp("zero00");
      send(32'd0, 32'd7, 1'b0);
`ifdef GCD_DRIVER_ZERO_BYPASS_EN
      check_bit("byp07_valid_next", bus.rsp_valid, 1'b1);
`endif
      get_rsp("zero07");
      repeat (3) @(posedge clk);
      #1;
`ifdef GCD_DRIVER_ZERO_BYPASS_EN
      check_word("zero_start_count", NB'(start_cnt - s0), NB'(0));
`else
      check_word("zero_start_count", NB'(start_cnt - s0), NB'(2));
`endif

      // 35,14 with backpressure: payload held, no new request accepted
      bus.rsp_ready = 1'b0;
      send(32'd35, 32'd14, 1'b0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         check_bit("bp_valid_held", bus.rsp_valid, 1'b1);
         check_word("bp_result_held", bus.rsp_result, 32'd7);
         check_bit("bp_req_ready_low", bus.req_ready, 1'b0);
         @(negedge clk);
      end
      get_rsp("bp");

      // timeout on a slow engine, then drain of the stray done
      eng_lat = 20;
      send(32'd1000, 32'd1, 1'b1);
      c0 = cyc;
      wait_valid();
      check_word("to_latency", NB'(cyc), NB'(c0 + 9));
      get_rsp("to");
      ready_in_drain = 1'b0;
      w = 0;
      @(negedge clk);
      while (!gcd_done && w < 100) begin
         if (bus.req_ready) ready_in_drain = 1'b1;
         @(negedge clk);
         w++;
      end
      check_bit("drain_done_seen", gcd_done, 1'b1);
      check_bit("drain_req_ready_low", bus.req_ready, 1'b0);
      check_bit("drain_ready_while_wait", ready_in_drain, 1'b0);
      @(posedge clk);
      #1;
      check_bit("drain_exit_ready", bus.req_ready, 1'b1);
      eng_lat = 2;
      send(32'd9, 32'd6, 1'b0);
      get_rsp("after_to");

      // asynchronous reset while waiting on the engine
      send(32'd12, 32'd18, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      send(32'd8, 32'd12, 1'b0);
      get_rsp("post_rst");

      // back-to-back random pairs
      s0 = start_cnt;
      for (int i = 0; i < 20; i++) begin
         ra = NB'($urandom_range(1, 500));
         rb = NB'($urandom_range(1, 500));
         send(ra, rb, 1'b0);
         get_rsp("rand");
      end
      check_word("rand_start_count", NB'(start_cnt - s0), NB'(20));
      check_bit("start_gap_ge2", (min_gap >= 2), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
